ddr3_cmd_sequencer: RTL and testbench

Host-side DDR3 command sequencer that sits directly upstream of the SDRAM memory model and drives its command/address/data interface. It runs the power-up sequence and issues ZQC, ACT, RD, WR and PRE with programmable spacing. Each accepted host request becomes one 4-beat burst: it serialises 64-bit write words onto the 16-bit data bus and assembles 4 read beats into one 64-bit response.

---
 rtl/ddr3_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_ddr3_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_sequencer.sv
`timescale 1ns/1ps
// DDR3 sequencer: power-up NOP/ZQC, then ACT -> RD/WR -> 4 beats -> PRE per request; all outputs registered, req_ready only while idle.
// Optional DDR3_SEQ_OPEN_PAGE_EN keeps the row open after a burst and precharges only on a row miss.
module ddr3_cmd_sequencer #(
  parameter int INIT_CYCLES = 16,
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2
) (
  input  logic        CK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [14:0] req_row,
  input  logic [5:0]  req_col,
  input  logic [63:0] req_wdata,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [14:0] ADDR,
  output logic [5:0]  COL,
  output logic [15:0] WR_DATA,
  input  logic [15:0] RD_DATA
);

`ifdef DDR3_SEQ_OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif

  localparam int CNT_W = $clog2(INIT_CYCLES + T_RCD + T_RP + 1);
  localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] RCD_LIM  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LIM   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] CMD_RST = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ZQC = 4'b0110;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_ZQ, S_IDLE, S_ACT, S_RCD_WAIT, S_WR_CMD, S_WR_BURST,
    S_RD_CMD, S_RD_BURST, S_PRE, S_RP_WAIT, S_ACTIVE_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       beat_q, beat_d;
  logic             write_q, write_d;
  logic             pend_act_q, pend_act_d;
  logic [14:0]      row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [47:0]      rd_buf_q, rd_buf_d;
  logic [63:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             req_ready_q, req_ready_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [5:0]       col_out_q, col_out_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    write_d    = write_q;
    pend_act_d = pend_act_q;
    row_d      = row_q;
    col_d      = col_q;
    wdata_d    = wdata_q;
    rd_buf_d   = rd_buf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    accept     = req_valid && req_ready_q;

    if (accept) begin
      write_d = req_write;
      row_d   = req_row;
      col_d   = req_col;
      wdata_d = req_wdata;
    end

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == INIT_LIM) state_d = S_ZQ;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      S_ZQ:   state_d = S_IDLE;
      S_IDLE: if (accept) state_d = S_ACT;
      S_ACTIVE_IDLE: begin
        if (accept) begin
          // Row hit goes straight to the column command; a miss closes the row first.
          if (req_row == row_q) begin
            state_d = req_write ? S_WR_CMD : S_RD_CMD;
          end else begin
            state_d    = S_PRE;
            pend_act_d = 1'b1;
          end
        end
      end
      S_ACT: begin
        cnt_d   = CNT_ONE;
        state_d = S_RCD_WAIT;
      end
      S_RCD_WAIT: begin
        if (cnt_q == RCD_LIM) state_d = write_q ? S_WR_CMD : S_RD_CMD;
        else                  cnt_d   = cnt_q + CNT_ONE;
      end
      S_WR_CMD: begin
        beat_d  = 2'd0;
        state_d = S_WR_BURST;
      end
      S_RD_CMD: begin
        beat_d  = 2'd0;
        state_d = S_RD_BURST;
      end
      S_WR_BURST, S_RD_BURST: begin
        if (state_q == S_RD_BURST) begin
          if (beat_q == 2'd3) begin
            rd_data_d  = {RD_DATA, rd_buf_q};
            rd_valid_d = 1'b1;
          end else begin
            rd_buf_d[{beat_q, 4'b0000} +: 16] = RD_DATA;
          end
        end
        if (beat_q == 2'd3) state_d = OPEN_PAGE ? S_ACTIVE_IDLE : S_PRE;
        else                beat_d  = beat_q + 2'd1;
      end
      S_PRE: begin
        cnt_d   = CNT_ONE;
        state_d = S_RP_WAIT;
      end
      S_RP_WAIT: begin
        if (cnt_q == RP_LIM) begin
          pend_act_d = 1'b0;
          state_d    = pend_act_q ? S_ACT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase

    // Pin values are derived from the next state so they line up with it after the edge.
    cmd_d       = CMD_NOP;
    col_out_d   = col_out_q;
    wr_data_d   = 16'h0000;
    req_ready_d = (state_d == S_IDLE) || (state_d == S_ACTIVE_IDLE);
    case (state_d)
      S_ZQ:       cmd_d = CMD_ZQC;
      S_ACT:      cmd_d = CMD_ACT;
      S_PRE:      cmd_d = CMD_PRE;
      S_WR_CMD: begin
        cmd_d     = CMD_WR;
        col_out_d = col_d;
      end
      S_RD_CMD: begin
        cmd_d     = CMD_RD;
        col_out_d = col_d;
      end
      S_WR_BURST: begin
        col_out_d = col_d + {4'b0000, beat_d};
        wr_data_d = wdata_d[{beat_d, 4'b0000} +: 16];
      end
      S_RD_BURST: col_out_d = col_d + {4'b0000, beat_d};
      default:    cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= '0;
      beat_q      <= 2'd0;
      write_q     <= 1'b0;
      pend_act_q  <= 1'b0;
      row_q       <= 15'd0;
      col_q       <= 6'd0;
      wdata_q     <= 64'd0;
      rd_buf_q    <= 48'd0;
      rd_data_q   <= 64'd0;
      rd_valid_q  <= 1'b0;
      req_ready_q <= 1'b0;
      cmd_q       <= CMD_RST;
      col_out_q   <= 6'd0;
      wr_data_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      write_q     <= write_d;
      pend_act_q  <= pend_act_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      req_ready_q <= req_ready_d;
      cmd_q       <= cmd_d;
      col_out_q   <= col_out_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign ADDR      = row_q;
  assign COL       = col_out_q;
  assign WR_DATA   = wr_data_q;
  assign req_ready = req_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ddr3_cmd_sequencer with a small behavioural SDRAM on the pins.
module tb_ddr3_cmd_sequencer;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101;
  localparam logic [3:0] WR = 4'b0100, PRE = 4'b0010, ZQC = 4'b0110, RST = 4'b1111;
  localparam logic [63:0] WDAT = 64'h4444_3333_2222_1111;
  localparam logic [63:0] DWRAP = 64'hDEAD_BEEF_CAFE_F00D;
`ifdef DDR3_SEQ_OPEN_PAGE_EN
  localparam int BEAT2_AT = 8;
`else
  localparam int BEAT2_AT = 6;
`endif

  logic        CK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [14:0] req_row = '0;
  logic [5:0]  req_col = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, rd_valid, CS_N, RAS_N, CAS_N, WE_N;
  logic [63:0] rd_data;
  logic [14:0] ADDR;
  logic [5:0]  COL;
  logic [15:0] WR_DATA, RD_DATA;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:1023];
  int          rd_cnt, wr_cnt;
  logic [3:0]  o_cmd  [0:19];
  logic [14:0] o_addr [0:19];
  logic [5:0]  o_col  [0:19];
  logic [15:0] o_wd   [0:19];
  logic        o_rdy  [0:19];
  logic        o_rv   [0:19];
  logic [63:0] o_rd   [0:19];

  ddr3_cmd_sequencer #(.INIT_CYCLES(16), .T_RCD(2), .T_RP(2)) dut (
    .CK(CK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N),
    .WE_N(WE_N), .ADDR(ADDR), .COL(COL), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA)
  );

  always #5 CK = ~CK;

  wire [3:0] cmd     = {CS_N, RAS_N, CAS_N, WE_N};
  wire [9:0] mem_idx = {ADDR[3:0], COL};
  assign RD_DATA = (rd_cnt > 0) ? mem[mem_idx] : 16'hzzzz;

  function automatic logic [15:0] fill(input logic [9:0] idx);
    return {6'h2A, idx};
  endfunction

  function automatic logic [63:0] exp_burst(input logic [3:0] row, input logic [5:0] col);
    logic [63:0] r;
    logic [5:0]  c;
    for (int k = 0; k < 4; k++) begin
      c = col + 6'(k);
      r[16*k +: 16] = fill({row, c});
    end
    return r;
  endfunction

  // Memory: data is on the bus the four cycles after RD/WR.
  always @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= fill(10'(i));
    end else begin
      if (wr_cnt > 0) begin
        mem[mem_idx] <= WR_DATA;
        wr_cnt <= wr_cnt - 1;
      end
      if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      if (cmd == WR) wr_cnt <= 4;
      if (cmd == RD) rd_cnt <= 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sample(input int i);
    o_cmd[i] = cmd;  o_addr[i] = ADDR; o_col[i] = COL; o_wd[i] = WR_DATA;
    o_rdy[i] = req_ready; o_rv[i] = rd_valid; o_rd[i] = rd_data;
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (req_ready !== 1'b1 && budget < 200) begin
      @(negedge CK);
      budget++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
  endtask

  // Present one request, drop valid after acceptance, record cycles t+1..t+n.
  task automatic run_burst(input logic wr, input logic [14:0] row, input logic [5:0] col,
                           input logic [63:0] wd, input int n);
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_row = row; req_col = col; req_wdata = wd;
    for (int i = 1; i <= n; i++) begin
      @(negedge CK);
      if (i == 1) req_valid = 1'b0;
      sample(i);
    end
  endtask

  task automatic test_init(input string tag);
    logic [3:0] exp_cmd;
    RESET_N = 1'b0;
    #1;
    checks++; if (cmd !== RST) begin errors++; $display("FAIL %s_rst_cmd: got %b want %b", tag, cmd, RST); end
    checks++; if (ADDR !== 15'd0) begin errors++; $display("FAIL %s_rst_addr: got %0d want 0", tag, ADDR); end
    checks++; if (COL !== 6'd0) begin errors++; $display("FAIL %s_rst_col: got %0d want 0", tag, COL); end
    checks++; if (WR_DATA !== 16'h0) begin errors++; $display("FAIL %s_rst_wdata: got %h want 0", tag, WR_DATA); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s_rst_ready: got %b want 0", tag, req_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rst_rdvalid: got %b want 0", tag, rd_valid); end
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL %s_rst_rddata: got %h want 0", tag, rd_data); end
    @(negedge CK);
    @(negedge CK);
    RESET_N = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge CK);
      exp_cmd = (n == 17) ? ZQC : NOP;
      checks++;
      if (cmd !== exp_cmd) begin errors++; $display("FAIL %s_init_cmd cycle %0d: got %b want %b", tag, n, cmd, exp_cmd); end
      checks++;
      if (req_ready !== (n == 18)) begin errors++; $display("FAIL %s_init_ready cycle %0d: got %b want %b", tag, n, req_ready, n == 18); end
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_init_rdvalid cycle %0d: got %b want 0", tag, n, rd_valid); end
    end
  endtask

`ifndef DDR3_SEQ_OPEN_PAGE_EN
  task automatic test_write();
    run_burst(1'b1, 15'd5, 6'd0, WDAT, 10);
    checks++; if (o_cmd[1] !== ACT) begin errors++; $display("FAIL wr_act: got %b want %b", o_cmd[1], ACT); end
    checks++; if (o_addr[1] !== 15'd5) begin errors++; $display("FAIL wr_act_addr: got %0d want 5", o_addr[1]); end
    checks++; if (o_rdy[1] !== 1'b0) begin errors++; $display("FAIL wr_busy_ready: got %b want 0", o_rdy[1]); end
    checks++; if (o_cmd[2] !== NOP) begin errors++; $display("FAIL wr_rcd_nop: got %b want %b", o_cmd[2], NOP); end
    checks++; if (o_cmd[3] !== WR) begin errors++; $display("FAIL wr_cmd: got %b want %b", o_cmd[3], WR); end
    checks++; if (o_col[3] !== 6'd0) begin errors++; $display("FAIL wr_cmd_col: got %0d want 0", o_col[3]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_wd[4+k] !== WDAT[16*k +: 16]) begin errors++; $display("FAIL wr_beat%0d_data: got %h want %h", k, o_wd[4+k], WDAT[16*k +: 16]); end
      checks++; if (o_col[4+k] !== 6'(k)) begin errors++; $display("FAIL wr_beat%0d_col: got %0d want %0d", k, o_col[4+k], k); end
      checks++; if (o_cmd[4+k] !== NOP) begin errors++; $display("FAIL wr_beat%0d_cmd: got %b want %b", k, o_cmd[4+k], NOP); end
      checks++; if (o_addr[4+k] !== 15'd5) begin errors++; $display("FAIL wr_beat%0d_addr: got %0d want 5", k, o_addr[4+k]); end
    end
    checks++; if (o_cmd[8] !== PRE) begin errors++; $display("FAIL wr_pre: got %b want %b", o_cmd[8], PRE); end
    checks++; if (o_rdy[9] !== 1'b0) begin errors++; $display("FAIL wr_rp_ready: got %b want 0", o_rdy[9]); end
    checks++; if (o_rdy[10] !== 1'b1) begin errors++; $display("FAIL wr_ready_back: got %b want 1", o_rdy[10]); end
  endtask

  task automatic test_read();
    run_burst(1'b0, 15'd5, 6'd0, 64'd0, 10);
    checks++; if (o_cmd[1] !== ACT) begin errors++; $display("FAIL rd_act: got %b want %b", o_cmd[1], ACT); end
    checks++; if (o_cmd[3] !== RD) begin errors++; $display("FAIL rd_cmd: got %b want %b", o_cmd[3], RD); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_col[4+k] !== 6'(k)) begin errors++; $display("FAIL rd_beat%0d_col: got %0d want %0d", k, o_col[4+k], k); end
    end
    checks++; if (o_rv[7] !== 1'b0) begin errors++; $display("FAIL rd_valid_early: got %b want 0", o_rv[7]); end
    checks++; if (o_rv[8] !== 1'b1) begin errors++; $display("FAIL rd_valid_pulse: got %b want 1", o_rv[8]); end
    checks++; if (o_rd[8] !== WDAT) begin errors++; $display("FAIL rd_data: got %h want %h", o_rd[8], WDAT); end
    checks++; if (o_cmd[8] !== PRE) begin errors++; $display("FAIL rd_pre: got %b want %b", o_cmd[8], PRE); end
    checks++; if (o_rv[9] !== 1'b0) begin errors++; $display("FAIL rd_valid_width: got %b want 0", o_rv[9]); end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_col;
    run_burst(1'b1, 15'd7, 6'd62, DWRAP, 10);
    checks++; if (o_col[3] !== 6'd62) begin errors++; $display("FAIL wrap_wr_cmd_col: got %0d want 62", o_col[3]); end
    for (int k = 0; k < 4; k++) begin
      exp_col = 6'd62 + 6'(k);
      checks++; if (o_col[4+k] !== exp_col) begin errors++; $display("FAIL wrap_wr_beat%0d_col: got %0d want %0d", k, o_col[4+k], exp_col); end
      checks++; if (o_addr[4+k] !== 15'd7) begin errors++; $display("FAIL wrap_wr_beat%0d_addr: got %0d want 7", k, o_addr[4+k]); end
    end
    run_burst(1'b0, 15'd7, 6'd62, 64'd0, 10);
    for (int k = 0; k < 4; k++) begin
      exp_col = 6'd62 + 6'(k);
      checks++; if (o_col[4+k] !== exp_col) begin errors++; $display("FAIL wrap_rd_beat%0d_col: got %0d want %0d", k, o_col[4+k], exp_col); end
    end
    checks++; if (o_rv[8] !== 1'b1) begin errors++; $display("FAIL wrap_rd_valid: got %b want 1", o_rv[8]); end
    checks++; if (o_rd[8] !== DWRAP) begin errors++; $display("FAIL wrap_rd_data: got %h want %h", o_rd[8], DWRAP); end
  endtask

  // A request held high through a busy burst is taken only once the sequencer is idle again.
  task automatic test_back_to_back();
    int extra_act = 0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_row = 15'd7; req_col = 6'd62; req_wdata = '0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge CK);
      if (i == 11) req_valid = 1'b0;
      sample(i);
      if (i >= 2 && i <= 10 && cmd == ACT) extra_act++;
    end
    checks++; if (o_cmd[1] !== ACT) begin errors++; $display("FAIL b2b_first_act: got %b want %b", o_cmd[1], ACT); end
    checks++; if (extra_act !== 0) begin errors++; $display("FAIL b2b_early_act: got %0d extra ACT want 0", extra_act); end
    checks++; if (o_rdy[10] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", o_rdy[10]); end
    checks++; if (o_cmd[11] !== ACT) begin errors++; $display("FAIL b2b_second_act: got %b want %b", o_cmd[11], ACT); end
    checks++; if (o_rv[8] !== 1'b1 || o_rd[8] !== DWRAP) begin errors++; $display("FAIL b2b_first_read: got %b/%h want 1/%h", o_rv[8], o_rd[8], DWRAP); end
    checks++; if (o_rv[18] !== 1'b1 || o_rd[18] !== DWRAP) begin errors++; $display("FAIL b2b_second_read: got %b/%h want 1/%h", o_rv[18], o_rd[18], DWRAP); end
  endtask
`else
  task automatic test_open_page();
    int acts = 0;
    run_burst(1'b0, 15'd9, 6'd0, 64'd0, 8);
    checks++; if (o_cmd[1] !== ACT || o_addr[1] !== 15'd9) begin errors++; $display("FAIL op_first_act: got %b/%0d want %b/9", o_cmd[1], o_addr[1], ACT); end
    checks++; if (o_cmd[3] !== RD) begin errors++; $display("FAIL op_first_rd: got %b want %b", o_cmd[3], RD); end
    checks++; if (o_rv[8] !== 1'b1 || o_rd[8] !== exp_burst(4'd9, 6'd0)) begin errors++; $display("FAIL op_first_data: got %b/%h want 1/%h", o_rv[8], o_rd[8], exp_burst(4'd9, 6'd0)); end
    checks++; if (o_rdy[8] !== 1'b1) begin errors++; $display("FAIL op_active_idle_ready: got %b want 1", o_rdy[8]); end
    run_burst(1'b0, 15'd9, 6'd4, 64'd0, 6);
    for (int i = 1; i <= 6; i++) if (o_cmd[i] == ACT || o_cmd[i] == PRE) acts++;
    checks++; if (o_cmd[1] !== RD) begin errors++; $display("FAIL op_hit_rd: got %b want %b", o_cmd[1], RD); end
    checks++; if (acts !== 0) begin errors++; $display("FAIL op_hit_no_act: got %0d ACT/PRE want 0", acts); end
    checks++; if (o_rv[6] !== 1'b1 || o_rd[6] !== exp_burst(4'd9, 6'd4)) begin errors++; $display("FAIL op_hit_data: got %b/%h want 1/%h", o_rv[6], o_rd[6], exp_burst(4'd9, 6'd4)); end
    run_burst(1'b0, 15'd10, 6'd0, 64'd0, 10);
    checks++; if (o_cmd[1] !== PRE) begin errors++; $display("FAIL op_miss_pre: got %b want %b", o_cmd[1], PRE); end
    checks++; if (o_cmd[3] !== ACT || o_addr[3] !== 15'd10) begin errors++; $display("FAIL op_miss_act: got %b/%0d want %b/10", o_cmd[3], o_addr[3], ACT); end
    checks++; if (o_cmd[5] !== RD) begin errors++; $display("FAIL op_miss_rd: got %b want %b", o_cmd[5], RD); end
    checks++; if (o_rv[10] !== 1'b1 || o_rd[10] !== exp_burst(4'd10, 6'd0)) begin errors++; $display("FAIL op_miss_data: got %b/%h want 1/%h", o_rv[10], o_rd[10], exp_burst(4'd10, 6'd0)); end
  endtask
`endif

  task automatic test_reset_mid();
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_row = 15'd3; req_col = 6'd0;
    req_wdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 1; i <= BEAT2_AT; i++) begin
      @(negedge CK);
      if (i == 1) req_valid = 1'b0;
    end
    checks++; if (WR_DATA !== 16'h4567) begin errors++; $display("FAIL mid_beat2_data: got %h want 4567", WR_DATA); end
    test_init("mid_reset");
  endtask

  initial begin
    #2;
    test_init("power_up");
`ifdef DDR3_SEQ_OPEN_PAGE_EN
    test_open_page();
`else
    test_write();
    test_read();
    test_wrap();
    test_back_to_back();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
